// File: rtl/cordic_pkg.sv
// cordic_pkg: shared function codes, widths, error result and arbiter
// state type for the CORDIC vectoring arbiter slice.
package cordic_pkg;

  localparam logic FUNC_TAN  = 1'b0;
  localparam logic FUNC_ROOT = 1'b1;

  localparam int DW_IN  = 7;
  localparam int DW_OUT = 16;

  localparam logic [15:0] ERR_RESULT = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cordic_rr_pick.sv
// cordic_rr_pick: combinational rotate-priority picker. Scans req upward
// starting at ptr (wrapping at N_REQ) and reports the first set bit as a
// one-hot vector and as an index, plus whether any request is present.
module cordic_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IW-1:0]    win_idx,
  output logic             any
);
  import cordic_pkg::*;

  // Walk offsets from farthest to nearest so the nearest set bit to ptr wins.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any        = |req;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_REQ]) begin
        win_idx = IW'((int'(ptr) + off) % N_REQ);
      end
    end
    win_onehot[win_idx] = any;
  end

endmodule

// File: rtl/cordic_vec_arbiter.sv
// cordic_vec_arbiter: shares one CORDIC vectoring core among N_REQ
// requesters with round-robin arbitration. The winner's operands are
// latched, the core is started, and the FUNC-selected result is returned
// to the winner with a one-cycle valid.
// Optional build macro CORDIC_ARB_TIMEOUT_EN adds a WAIT watchdog that
// returns ERR_RESULT with rsp_err set after TIMEOUT_CYC idle cycles.
module cordic_vec_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DW_IN       = cordic_pkg::DW_IN,
  parameter int DW_OUT      = cordic_pkg::DW_OUT,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_func,
  input  logic [N_REQ*DW_IN-1:0]   req_x,
  input  logic [N_REQ*DW_IN-1:0]   req_y,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DW_OUT-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     core_start,
  output logic                     core_func,
  output logic [DW_IN-1:0]         core_x,
  output logic [DW_IN-1:0]         core_y,
  input  logic                     core_done,
  input  logic [DW_OUT-1:0]        core_tan,
  input  logic [DW_OUT-1:0]        core_root
);
  import cordic_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t         state, state_n;
  logic [IW-1:0]      ptr, ptr_n;
  logic [IW-1:0]      owner, owner_n;
  logic [N_REQ-1:0]   gnt_n, rsp_valid_n;
  logic [DW_OUT-1:0]  rsp_data_n;
  logic               core_start_n, core_func_n;
  logic [DW_IN-1:0]   core_x_n, core_y_n;

  logic [N_REQ-1:0]   win_onehot;
  logic [IW-1:0]      win_idx;
  logic               win_any;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;
  logic               rsp_err_n;
`endif

  cordic_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any        (win_any)
  );

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    owner_n      = owner;
    gnt_n        = '0;
    rsp_valid_n  = '0;
    rsp_data_n   = rsp_data;
    core_start_n = 1'b0;
    core_func_n  = core_func;
    core_x_n     = core_x;
    core_y_n     = core_y;
`ifdef CORDIC_ARB_TIMEOUT_EN
    wait_cnt_n   = wait_cnt;
    rsp_err_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_any) begin
          state_n      = WAIT;
          owner_n      = win_idx;
          gnt_n        = win_onehot;
          core_start_n = 1'b1;
          core_func_n  = req_func[win_idx];
          core_x_n     = req_x[win_idx*DW_IN +: DW_IN];
          core_y_n     = req_y[win_idx*DW_IN +: DW_IN];
`ifdef CORDIC_ARB_TIMEOUT_EN
          wait_cnt_n   = '0;
`endif
        end
      end
      WAIT: begin
        if (core_done) begin
          state_n     = RESP;
          rsp_valid_n = N_REQ'(1) << owner;
          rsp_data_n  = (core_func == FUNC_ROOT) ? core_root : core_tan;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYC)) begin
          state_n     = RESP;
          rsp_valid_n = N_REQ'(1) << owner;
          rsp_data_n  = DW_OUT'(ERR_RESULT);
          rsp_err_n   = 1'b1;
        end else begin
          wait_cnt_n  = wait_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        state_n = IDLE;
        ptr_n   = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, pointer, operand latches and outputs; reset discards any in-flight work.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      core_start <= 1'b0;
      core_func  <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      owner      <= owner_n;
      gnt        <= gnt_n;
      rsp_valid  <= rsp_valid_n;
      rsp_data   <= rsp_data_n;
      core_start <= core_start_n;
      core_func  <= core_func_n;
      core_x     <= core_x_n;
      core_y     <= core_y_n;
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  // Watchdog counter and error flag registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      rsp_err  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      rsp_err  <= rsp_err_n;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
// tb_cordic_vec_arbiter: self-checking bench for cordic_vec_arbiter with
// directed scenarios followed by randomized traffic, checked against a
// transaction-level round-robin model kept in the bench.
module tb_cordic_vec_arbiter;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [3:0]  req, req_func;
  logic [27:0] req_x, req_y;
  logic [3:0]  gnt, rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err, core_start, core_func;
  logic [6:0]  core_x, core_y;
  logic        core_done;
  logic [15:0] core_tan, core_root;

  int checks = 0;
  int errors = 0;
  int refPtr = 0;

  always #5 CLK = ~CLK;

  cordic_vec_arbiter #(
    .N_REQ       (4),
    .DW_IN       (7),
    .DW_OUT      (16),
    .TIMEOUT_CYC (32)
  ) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .req        (req),
    .req_func   (req_func),
    .req_x      (req_x),
    .req_y      (req_y),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .core_start (core_start),
    .core_func  (core_func),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_done  (core_done),
    .core_tan   (core_tan),
    .core_root  (core_root)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Round-robin rule: first requesting index at or above the pointer, wrapping.
  function automatic int expWinner(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (r[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input int k, input logic f, input logic [6:0] x, input logic [6:0] y);
    req_func[k]      = f;
    req_x[k*7 +: 7]  = x;
    req_y[k*7 +: 7]  = y;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, gnt, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_data"}, rsp_data, 0);
    checkOutput({tag, "_rsp_err"}, rsp_err, 0);
    checkOutput({tag, "_core_start"}, core_start, 0);
    checkOutput({tag, "_core_func"}, core_func, 0);
    checkOutput({tag, "_core_x"}, core_x, 0);
    checkOutput({tag, "_core_y"}, core_y, 0);
  endtask

  task automatic applyReset();
    reset_n   = 1'b0;
    req       = '0;
    core_done = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkAllZero("reset");
    @(negedge CLK);
    reset_n = 1'b1;
    refPtr  = 0;
  endtask

  // One full grant/compute/response transaction from the current IDLE cycle.
  task automatic doTransaction(input int latency, input logic [15:0] tanVal, input logic [15:0] rootVal,
                               input logic [3:0] lateMask, input bit keepReq);
    int w;
    logic expFunc;
    logic [6:0] expX, expY;
    w = expWinner(req, refPtr);
    if (w < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL txn_setup: got no requester, expected a requester");
      return;
    end
    expFunc = req_func[w];
    expX    = req_x[w*7 +: 7];
    expY    = req_y[w*7 +: 7];
    tick();
    checkOutput("gnt", gnt, 32'(1) << w);
    checkOutput("core_start", core_start, 1);
    checkOutput("core_func", core_func, expFunc);
    checkOutput("core_x", core_x, expX);
    checkOutput("core_y", core_y, expY);
    if (!keepReq) req[w] = 1'b0;
    req = req | lateMask;
    for (int i = 0; i < latency; i++) begin
      tick();
      checkOutput("wait_no_gnt", gnt, 0);
      checkOutput("wait_no_start", core_start, 0);
      checkOutput("wait_no_rsp", rsp_valid, 0);
      checkOutput("wait_core_x_hold", core_x, expX);
      checkOutput("wait_core_y_hold", core_y, expY);
      checkOutput("wait_core_func_hold", core_func, expFunc);
    end
    core_tan  = tanVal;
    core_root = rootVal;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    core_tan  = 16'($urandom);
    core_root = 16'($urandom);
    checkOutput("rsp_valid", rsp_valid, 32'(1) << w);
    checkOutput("rsp_data", rsp_data, expFunc ? rootVal : tanVal);
    checkOutput("rsp_err", rsp_err, 0);
    refPtr = (w + 1) % 4;
    tick();
    checkOutput("resp_valid_clear", rsp_valid, 0);
    checkOutput("resp_no_gnt", gnt, 0);
  endtask

  initial begin
    int w;
    reset_n   = 1'b0;
    req       = '0;
    req_func  = '0;
    req_x     = '0;
    req_y     = '0;
    core_done = 1'b0;
    core_tan  = '0;
    core_root = '0;
    #2;
    checkAllZero("por");
    applyReset();
    tick();
    checkAllZero("post_reset");

    // Single request from requester 2, TAN, done 14 cycles after start.
    applyStimulus(2, 1'b0, 7'd9, 7'd5);
    req = 4'b0100;
    doTransaction(14, 16'h1234, 16'hABCD, 4'b0000, 1'b0);

    // All four requesting continuously from reset: rotation 0,1,2,3,0.
    applyReset();
    for (int k = 0; k < 4; k++) applyStimulus(k, 1'($urandom), 7'($urandom), 7'($urandom));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) doTransaction(3 + n, 16'($urandom), 16'($urandom), 4'b0000, 1'b1);
    req = 4'b0000;

    // ROOT path with operands held stable through the operation.
    applyStimulus(1, 1'b1, 7'd3, 7'd4);
    req = 4'b0010;
    doTransaction(6, 16'h7777, 16'h0500, 4'b0000, 1'b0);

    // Stray done in IDLE, then req[0] raised while requester 3 is in WAIT.
    core_tan  = 16'h4444;
    core_root = 16'h5555;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkOutput("stray_done_rsp", rsp_valid, 0);
    tick();
    checkOutput("stray_done_rsp_late", rsp_valid, 0);
    checkOutput("stray_done_gnt", gnt, 0);
    applyStimulus(3, 1'b0, 7'd17, 7'd33);
    applyStimulus(0, 1'b1, 7'd64, 7'd100);
    req = 4'b1000;
    doTransaction(4, 16'h0101, 16'h0202, 4'b0001, 1'b0);
    doTransaction(2, 16'h0303, 16'h0404, 4'b0000, 1'b0);

    // Done arriving on the 33rd WAIT cycle is a normal result in either build.
    applyStimulus(2, 1'b0, 7'd1, 7'd2);
    req = 4'b0100;
    doTransaction(32, 16'h2468, 16'h1357, 4'b0000, 1'b0);

    // Reset during WAIT: outputs clear immediately, result discarded, pointer back to 0.
    applyStimulus(0, 1'b0, 7'd11, 7'd12);
    req = 4'b0001;
    doTransaction(1, 16'h0A0A, 16'h0B0B, 4'b0000, 1'b0);
    applyStimulus(2, 1'b1, 7'd21, 7'd22);
    req = 4'b0100;
    tick();
    checkOutput("rst_mid_gnt", gnt, 32'b0100);
    req = 4'b0000;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("rst_mid_async");
    core_done = 1'b1;
    core_root = 16'h3C3C;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset_n   = 1'b1;
    core_done = 1'b0;
    refPtr    = 0;
    tick();
    checkOutput("rst_mid_no_rsp", rsp_valid, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkOutput("rst_mid_stray_done", rsp_valid, 0);
    tick();
    checkOutput("rst_mid_stray_done_late", rsp_valid, 0);
    for (int k = 0; k < 4; k++) applyStimulus(k, 1'($urandom), 7'($urandom), 7'($urandom));
    req = 4'b1101;
    doTransaction(5, 16'h0F0F, 16'hF0F0, 4'b0000, 1'b0);
    req = 4'b0000;

    // Watchdog: core never answers.
    applyStimulus(1, 1'b1, 7'd40, 7'd41);
    req = 4'b0010;
    w = expWinner(req, refPtr);
    tick();
    checkOutput("wd_gnt", gnt, 32'(1) << w);
    req = 4'b0000;
`ifdef CORDIC_ARB_TIMEOUT_EN
    for (int i = 0; i < 32; i++) begin
      tick();
      checkOutput("wd_no_rsp_early", rsp_valid, 0);
    end
    tick();
    checkOutput("wd_rsp_valid", rsp_valid, 32'(1) << w);
    checkOutput("wd_rsp_err", rsp_err, 1);
    checkOutput("wd_rsp_data", rsp_data, 32'h8000);
    refPtr = (w + 1) % 4;
    tick();
    checkOutput("wd_rsp_clear", rsp_valid, 0);
    checkOutput("wd_err_clear", rsp_err, 0);
`else
    for (int i = 0; i < 60; i++) begin
      tick();
      checkOutput("wd_off_no_rsp", rsp_valid, 0);
    end
    applyReset();
`endif

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 4; k++) applyStimulus(k, 1'($urandom), 7'($urandom), 7'($urandom));
      req = 4'($urandom);
      if (req == 4'b0000) begin
        tick();
        checkOutput("rand_idle_no_gnt", gnt, 0);
        checkOutput("rand_idle_no_start", core_start, 0);
      end else begin
        doTransaction(int'($urandom_range(0, 10)), 16'($urandom), 16'($urandom), 4'b0000, 1'b0);
      end
    end
    req = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
